mlu_adder_acc: RTL and testbench
================================

// Module: mlu_adder_acc
// PURPOSE
//  Downstream stage of the 16-lane multiplier layer in the PuDianNao MLU datapath.
//  Takes the 16 products per beat and reduces them to one sum through a 4-level
//  pipelined adder tree. Accumulates those sums over a group of beats closed by
//  in_last, then presents one result on a valid/ready output.
//  Dot products and distances (k-NN, k-means, linear regression) use it.
// PARAMETERS
//  WIDTH  16  lane width of each product, signed two's complement
//  LANES  16  number of product lanes; fixed at 16 (4 tree levels)
//  ACC_W  32  accumulator/output width; must be >= WIDTH+4
//  CNT_W  8   beat-counter width
// PORTS
//  clk        in   1            single clock; all state updates on posedge
//  rst_n      in   1            synchronous, active-low reset
//  prod_in    in   WIDTH x16    product lanes [15:0] from the multiplier layer
//  in_valid   in   1            prod_in/in_last valid this cycle
//  in_last    in   1            this beat closes the accumulation group
//  in_ready   out  1            stage can accept a beat
//  acc_out    out  ACC_W        accumulated group sum
//  beat_cnt   out  CNT_W        beats in the reported group, saturating at 2^CNT_W-1
//  out_valid  out  1            acc_out/beat_cnt valid
//  out_ready  in   1            consumer accepts the result
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all pipe valids=0, acc=0, beat count=0, first=1.
//    Outputs: in_ready=1, out_valid=0, acc_out=0, beat_cnt=0.
//  - Beat accept: in_valid && in_ready. stall = out_valid && !out_ready.
//    in_ready = !stall. While stall, the whole pipe and the accumulator freeze.
//  - Tree: S1 sums 16->8 lanes, S2 8->4, S3 4->2, S4 2->1, each registered.
//    Every operand is sign-extended to ACC_W before addition, so tree sums never wrap.
//    Each stage carries a valid bit and a last bit.
//  - Accumulator: when S4 is valid and the pipe is not stalled:
//    - if first=1, acc = S4 sum, else acc = acc + S4 sum;
//    - the beat counter increments with the same load/add rule (load gives 1).
//  - S4 valid with last=1: on the same edge, acc_out and beat_cnt are registered,
//    out_valid goes to 1, and first is set to 1.
//  - Latency: last beat accepted at edge E0 -> out_valid=1 after edge E5.
//    Throughput is 1 beat/cycle with no bubbles while out_ready=1.
//  - Output handshake: out_valid && out_ready clears out_valid. In that same cycle
//    the pipe advances, so a following group's final result may set out_valid again
//    on that edge (back-to-back results).
//  - Single-beat group (in_last on the first beat): acc_out = that beat's tree sum,
//    beat_cnt = 1.
//  - Accumulate overflow: two's-complement wrap at ACC_W (default build).
//  - Reset mid-group: in-flight beats and the partial acc are discarded;
//    no out_valid follows.
//  - in_valid=0 beats are not counted; gaps in the pipe are allowed mid-group.
// CONFIGURATION
//  MLU_ACC_SATURATE_EN
//  - Defined: an accumulate that overflows clamps acc to +2^(ACC_W-1)-1 or
//    -2^(ACC_W-1). A sticky sat_flag (extra output, 1 bit) is reported alongside
//    acc_out and cleared when each group starts.
//  - Undefined: wrap only; the sat_flag port is absent.
// STRUCTURE
//  - Package mlu_pkg: WIDTH, LANES, ACC_W constants; lane_t = logic signed [WIDTH-1:0];
//    acc_t = logic signed [ACC_W-1:0]; typedef struct {acc_t sum; logic vld; logic last;}
//    tree_stage_t.
//  - Sub-module add_tree_level #(N_IN): one registered pairwise-add level with
//    enable (=!stall), instanced 4 times (N_IN = 16, 8, 4, 2).
//  - Top holds the accumulator, counter, first flag and output register.
// TESTING
//  1. Reset: rst_n=0 for 3 cycles -> out_valid=0, acc_out=0, in_ready=1.
//  2. Single beat, all lanes=1, in_last=1, out_ready=1 -> 5 cycles later acc_out=16,
//     beat_cnt=1, out_valid for 1 cycle.
//  3. Group of 4 beats, lane i=i-8 (signed), last on beat 4 -> acc_out=4*(-8)=-32,
//     beat_cnt=4.
//  4. Backpressure: out_ready=0 for 10 cycles with 2 groups streaming -> in_ready=0
//     while the first result is held. acc_out is stable, and no beat is lost or
//     duplicated after release (second result correct).
//  5. Back-to-back 1-beat groups every cycle, out_ready=1 -> one result per cycle,
//     each equal to its own beat sum (first-flag load verified).
//  6. Overflow: ACC_W=20, 16 lanes=0x7FFF, 4 beats -> default build wraps mod 2^20.
//     With MLU_ACC_SATURATE_EN: acc_out=0x7FFFF, sat_flag=1. Also assert reset
//     mid-group -> no out_valid.

Source files
------------

// File: rtl/mlu_pkg.sv
// Shared constants and types for the MLU adder/accumulator stage.
package mlu_pkg;
  localparam int WIDTH = 16;
  localparam int LANES = 16;
  localparam int ACC_W = 32;
  localparam int CNT_W = 8;

  typedef logic signed [WIDTH-1:0] lane_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    acc_t sum;
    logic vld;
    logic last;
  } tree_stage_t;

  // Signed add overflows when both operands agree in sign and the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
endpackage

// File: rtl/mlu_adder_acc_tree.sv
// One registered pairwise-add level of the product reduction tree.
module add_tree_level #(
  parameter int N_IN  = 16,
  parameter int ACC_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [N_IN*ACC_W-1:0]        in_sum,
  input  logic                         in_vld,
  input  logic                         in_last,
  output logic [(N_IN/2)*ACC_W-1:0]    out_sum,
  output logic                         out_vld,
  output logic                         out_last
);
  import mlu_pkg::*;

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*ACC_W-1:0] sum_nxt;
  logic signed [ACC_W-1:0] op_a;
  logic signed [ACC_W-1:0] op_b;

  always_comb begin
    sum_nxt = '0;
    op_a    = '0;
    op_b    = '0;
    for (int i = 0; i < N_OUT; i++) begin
      op_a = in_sum[(2*i)*ACC_W +: ACC_W];
      op_b = in_sum[(2*i+1)*ACC_W +: ACC_W];
      sum_nxt[i*ACC_W +: ACC_W] = op_a + op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
    end else if (en) begin
      out_vld <= in_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      out_sum  <= sum_nxt;
      out_last <= in_last;
    end
  end
endmodule

// File: rtl/mlu_adder_acc.sv
// 16-lane product reduction tree plus group accumulator with valid/ready result.
// Optional clamping accumulate with sticky sat_flag: define MLU_ACC_SATURATE_EN.
module mlu_adder_acc #(
  parameter int WIDTH = mlu_pkg::WIDTH,
  parameter int LANES = mlu_pkg::LANES,
  parameter int ACC_W = mlu_pkg::ACC_W,
  parameter int CNT_W = mlu_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LANES-1:0][WIDTH-1:0]   prod_in,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic signed [ACC_W-1:0]       acc_out,
  output logic [CNT_W-1:0]              beat_cnt,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef MLU_ACC_SATURATE_EN
  ,
  output logic                          sat_flag
`endif
);
  import mlu_pkg::*;

  logic en;
  logic [LANES-1:0][WIDTH-1:0] prod_p0;
  logic vld_p0, last_p0;
  logic signed [WIDTH-1:0] lane;
  logic [LANES*ACC_W-1:0] ext_p0;
  logic [(LANES/2)*ACC_W-1:0] sum_p1;
  logic [(LANES/4)*ACC_W-1:0] sum_p2;
  logic [(LANES/8)*ACC_W-1:0] sum_p3;
  logic signed [ACC_W-1:0] sum_p4;
  logic vld_p1, vld_p2, vld_p3, vld_p4;
  logic last_p1, last_p2, last_p3, last_p4;

  logic signed [ACC_W-1:0] acc, acc_nxt, sum_raw;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic first;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

`ifdef MLU_ACC_SATURATE_EN
  logic ovf, sat_acc, sat_nxt;

  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W-1:0] raw,
                                                        input logic ovf_in,
                                                        input logic neg);
    if (!ovf_in) return raw;
    return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction
`endif

  // A held result blocks the whole pipe; nothing moves until it is taken.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Stage p0: input capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      prod_p0 <= prod_in;
      last_p0 <= in_last;
    end
  end

  always_comb begin
    ext_p0 = '0;
    lane   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = prod_p0[i];
      ext_p0[i*ACC_W +: ACC_W] = ACC_W'(lane);
    end
  end

  // Stages p1..p4: reduction tree 16 -> 8 -> 4 -> 2 -> 1
  add_tree_level #(.N_IN(LANES), .ACC_W(ACC_W)) u_lvl1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_sum(ext_p0), .in_vld(vld_p0), .in_last(last_p0),
    .out_sum(sum_p1), .out_vld(vld_p1), .out_last(last_p1)
  );
  add_tree_level #(.N_IN(LANES/2), .ACC_W(ACC_W)) u_lvl2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_sum(sum_p1), .in_vld(vld_p1), .in_last(last_p1),
    .out_sum(sum_p2), .out_vld(vld_p2), .out_last(last_p2)
  );
  add_tree_level #(.N_IN(LANES/4), .ACC_W(ACC_W)) u_lvl3 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_sum(sum_p2), .in_vld(vld_p2), .in_last(last_p2),
    .out_sum(sum_p3), .out_vld(vld_p3), .out_last(last_p3)
  );
  add_tree_level #(.N_IN(LANES/8), .ACC_W(ACC_W)) u_lvl4 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_sum(sum_p3), .in_vld(vld_p3), .in_last(last_p3),
    .out_sum(sum_p4), .out_vld(vld_p4), .out_last(last_p4)
  );

  // Accumulate stage: first beat of a group loads, later beats add
  always_comb begin
    sum_raw = acc + sum_p4;
    cnt_nxt = first ? CNT_W'(1) : cnt_inc(cnt);
`ifdef MLU_ACC_SATURATE_EN
    ovf     = add_ovf(acc[ACC_W-1], sum_p4[ACC_W-1], sum_raw[ACC_W-1]);
    acc_nxt = first ? sum_p4 : sat_clamp(sum_raw, ovf, acc[ACC_W-1]);
    sat_nxt = first ? 1'b0 : (sat_acc | ovf);
`else
    acc_nxt = first ? sum_p4 : sum_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      first     <= 1'b1;
      acc_out   <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
`ifdef MLU_ACC_SATURATE_EN
      sat_acc   <= 1'b0;
      sat_flag  <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (en && vld_p4) begin
        acc   <= acc_nxt;
        cnt   <= cnt_nxt;
        first <= last_p4;
`ifdef MLU_ACC_SATURATE_EN
        sat_acc <= sat_nxt;
`endif
        if (last_p4) begin
          acc_out   <= acc_nxt;
          beat_cnt  <= cnt_nxt;
          out_valid <= 1'b1;
`ifdef MLU_ACC_SATURATE_EN
          sat_flag  <= sat_nxt;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_mlu_adder_acc.sv
// Directed bench for mlu_adder_acc: a 32-bit accumulator instance and a 20-bit
// one for overflow, fed the same stimulus.
module tb_mlu_adder_acc;
  typedef logic [15:0][15:0] beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  beat_t prod_in = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid;
  logic [31:0] acc_out;
  logic [7:0] beat_cnt;
  logic in_ready20, out_valid20;
  logic [19:0] acc_out20;
  logic [7:0] beat_cnt20;
`ifdef MLU_ACC_SATURATE_EN
  logic sat_flag, sat_flag20;
  logic sat20_q[$];
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [31:0] res_acc[$];
  logic [7:0]  res_cnt[$];
  int          res_cyc[$];
  logic [19:0] res20_acc[$];
  logic [7:0]  res20_cnt[$];

  mlu_adder_acc dut (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .acc_out(acc_out), .beat_cnt(beat_cnt), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MLU_ACC_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  mlu_adder_acc #(.ACC_W(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready20), .acc_out(acc_out20), .beat_cnt(beat_cnt20), .out_valid(out_valid20),
    .out_ready(out_ready)
`ifdef MLU_ACC_SATURATE_EN
    , .sat_flag(sat_flag20)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      res_acc.push_back(acc_out);
      res_cnt.push_back(beat_cnt);
      res_cyc.push_back(cyc);
    end
    if (rst_n && out_valid20 && out_ready) begin
      res20_acc.push_back(acc_out20);
      res20_cnt.push_back(beat_cnt20);
`ifdef MLU_ACC_SATURATE_EN
      sat20_q.push_back(sat_flag20);
`endif
    end
  end

  task automatic clear_q();
    res_acc.delete(); res_cnt.delete(); res_cyc.delete();
    res20_acc.delete(); res20_cnt.delete();
`ifdef MLU_ACC_SATURATE_EN
    sat20_q.delete();
`endif
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic beat_t fill(input logic [15:0] v);
    beat_t b;
    for (int i = 0; i < 16; i++) b[i] = v;
    return b;
  endfunction

  task automatic send_beat(input beat_t v, input logic last);
    int t;
    prod_in = v; in_valid = 1'b1; in_last = last;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL send_beat_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
    end
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int t;
    t = 0;
    while (res_acc.size() < n && t < budget) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++;
    if (res_acc.size() < n) begin
      n_fail++;
      $display("FAIL wait_results: got %0d results required %0d", res_acc.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(3);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (acc_out !== 32'd0) begin n_fail++; $display("FAIL reset_acc_out: got %h required 0", acc_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_cmp++; if (beat_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d required 0", beat_cnt); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    clear_q();
    out_ready = 1'b1;
    send_beat(fill(16'd1), 1'b1);
    wait_results(1, 20);
    n_cmp++; if (res_acc[0] !== 32'd16) begin n_fail++; $display("FAIL single_acc: got %0d required 16", $signed(res_acc[0])); end
    n_cmp++; if (res_cnt[0] !== 8'd1) begin n_fail++; $display("FAIL single_cnt: got %0d required 1", res_cnt[0]); end
    n_cmp++; if (res_cyc[0] - acc_cyc !== 5) begin n_fail++; $display("FAIL single_latency: got %0d edges required 5", res_cyc[0] - acc_cyc); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_pulse: out_valid=%b required 0", out_valid); end
    step(6);
    n_cmp++; if (res_acc.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d results required 1", res_acc.size()); end
  endtask

  task automatic test_group4();
    beat_t b;
    clear_q();
    for (int i = 0; i < 16; i++) b[i] = 16'(i - 8);
    for (int k = 0; k < 4; k++) send_beat(b, k == 3);
    wait_results(1, 20);
    n_cmp++; if (res_acc[0] !== 32'hFFFF_FFE0) begin n_fail++; $display("FAIL group4_acc: got %0d required -32", $signed(res_acc[0])); end
    n_cmp++; if (res_cnt[0] !== 8'd4) begin n_fail++; $display("FAIL group4_cnt: got %0d required 4", res_cnt[0]); end
    n_cmp++; if (res20_acc[0] !== 20'hFFFE0) begin n_fail++; $display("FAIL group4_acc20: got %h required fffe0", res20_acc[0]); end
  endtask

  task automatic test_backpressure();
    beat_t b;
    int t;
    logic bad_ready, bad_acc;
    clear_q();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) b[i] = 16'(i);
    send_beat(fill(16'd2), 1'b0);
    send_beat(fill(16'd2), 1'b1);
    send_beat(b, 1'b0);
    send_beat(b, 1'b0);
    send_beat(b, 1'b1);
    t = 0;
    while (out_valid !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b required 1", out_valid); end
    bad_ready = 1'b0; bad_acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0) bad_ready = 1'b1;
      if (acc_out !== 32'd64 || beat_cnt !== 8'd2) bad_acc = 1'b1;
      step(1);
    end
    n_cmp++; if (bad_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_held: in_ready rose during stall, required 0"); end
    n_cmp++; if (bad_acc !== 1'b0) begin n_fail++; $display("FAIL bp_acc_stable: acc_out=%0d cnt=%0d required 64/2 throughout", acc_out, beat_cnt); end
    n_cmp++; if (res_acc.size() !== 0) begin n_fail++; $display("FAIL bp_no_handshake: got %0d results required 0", res_acc.size()); end
    out_ready = 1'b1;
    wait_results(2, 30);
    step(6);
    n_cmp++; if (res_acc[0] !== 32'd64 || res_cnt[0] !== 8'd2) begin n_fail++; $display("FAIL bp_res_a: got %0d/%0d required 64/2", res_acc[0], res_cnt[0]); end
    n_cmp++; if (res_acc[1] !== 32'd360 || res_cnt[1] !== 8'd3) begin n_fail++; $display("FAIL bp_res_b: got %0d/%0d required 360/3", res_acc[1], res_cnt[1]); end
    n_cmp++; if (res_acc.size() !== 2) begin n_fail++; $display("FAIL bp_count: got %0d results required 2", res_acc.size()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] lane_v[6] = '{16'hFFFC, 16'hFFFF, 16'd2, 16'd5, 16'd8, 16'd11};
    logic [31:0] exp_v[6]  = '{32'hFFFF_FFC0, 32'hFFFF_FFF0, 32'd32, 32'd80, 32'd128, 32'd176};
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) send_beat(fill(lane_v[k]), 1'b1);
    wait_results(6, 20);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (res_acc[k] !== exp_v[k] || res_cnt[k] !== 8'd1) begin
        n_fail++; $display("FAIL b2b_res%0d: got %0d/%0d required %0d/1", k, $signed(res_acc[k]), res_cnt[k], $signed(exp_v[k]));
      end
    end
    for (int k = 1; k < 6; k++) begin
      n_cmp++;
      if (res_cyc[k] - res_cyc[k-1] !== 1) begin
        n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles required 1", k, res_cyc[k] - res_cyc[k-1]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send_beat(fill(16'h7FFF), k == 3);
    wait_results(1, 20);
    n_cmp++; if (res_acc[0] !== 32'h001F_FFC0) begin n_fail++; $display("FAIL ovf_acc32: got %h required 001fffc0", res_acc[0]); end
    n_cmp++; if (res20_cnt[0] !== 8'd4) begin n_fail++; $display("FAIL ovf_cnt20: got %0d required 4", res20_cnt[0]); end
`ifdef MLU_ACC_SATURATE_EN
    n_cmp++; if (res20_acc[0] !== 20'h7FFFF) begin n_fail++; $display("FAIL ovf_acc20_sat: got %h required 7ffff", res20_acc[0]); end
    n_cmp++; if (sat20_q[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_sat_flag: got %b required 1", sat20_q[0]); end
`else
    n_cmp++; if (res20_acc[0] !== 20'hFFFC0) begin n_fail++; $display("FAIL ovf_acc20_wrap: got %h required fffc0", res20_acc[0]); end
`endif
  endtask

  task automatic test_reset_mid_group();
    clear_q();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) send_beat(fill(16'd1), 1'b0);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(12);
    n_cmp++; if (res_acc.size() !== 0) begin n_fail++; $display("FAIL midrst_no_result: got %0d results required 0", res_acc.size()); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
    send_beat(fill(16'd3), 1'b1);
    wait_results(1, 20);
    n_cmp++; if (res_acc[0] !== 32'd48 || res_cnt[0] !== 8'd1) begin n_fail++; $display("FAIL midrst_fresh_group: got %0d/%0d required 48/1", res_acc[0], res_cnt[0]); end
  endtask

  initial begin
    step(1);
    test_reset();
    test_single();
    test_group4();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_group();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
